// File: rtl/keen_imm_extender.sv
// Registered RISC-V immediate generator / sign extender with a valid/ready handshake.
// Define KEEN_IMM_EXTENDER_SKID_EN to use a 2-entry skid buffer with a registered in_ready.
module keen_imm_extender #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_fmt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_Z = 3'd5
    } fmt_e;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("keen_imm_extender: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]     imm32;
    logic [XLEN-1:0] new_imm;
    logic            new_ill;
    logic            accept;
    logic            consume;

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    logic            main_ill_q,   main_ill_d;

    // Every format except Z (and reserved) is a signed 32-bit value, so one
    // signed widening covers the XLEN=64 case including U.
    always_comb begin
        imm32   = 32'd0;
        new_ill = 1'b0;
        case (in_fmt)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'd0};
            FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z:   imm32 = {27'd0, in_instr[19:15]};
            default: new_ill = 1'b1;
        endcase
    end

    assign new_imm     = XLEN'($signed(imm32));
    assign accept      = in_valid && in_ready;
    assign consume     = main_valid_q && out_ready;
    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_illegal = main_ill_q;

`ifdef KEEN_IMM_EXTENDER_SKID_EN
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            skid_ill_q,   skid_ill_d;
    logic            rdy_q;

    assign in_ready = rdy_q;

    // A beat arriving while the main register stalls parks in the skid slot
    // and moves forward on the cycle the main beat is consumed.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;
        if (skid_valid_q) begin
            if (consume) begin
                main_imm_d   = skid_imm_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || consume) begin
                main_valid_d = 1'b1;
                main_imm_d   = new_imm;
                main_ill_d   = new_ill;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = new_imm;
                skid_ill_d   = new_ill;
            end
        end else if (consume) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
            rdy_q        <= !skid_valid_d;
        end
    end
`else
    logic alive_q;

    // alive_q keeps in_ready low through reset and the first cycle after it.
    assign in_ready = alive_q && (!main_valid_q || out_ready);

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_ill_d   = main_ill_q;
        if (accept) begin
            main_valid_d = 1'b1;
            main_imm_d   = new_imm;
            main_ill_d   = new_ill;
        end else if (consume) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_ill_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_ill_q   <= main_ill_d;
        end
    end

endmodule

// File: tb/tb_keen_imm_extender.sv
// Self-checking bench for keen_imm_extender: XLEN=32 and XLEN=64 instances share
// one stimulus stream and are compared against a queue-based reference model.
module tb_keen_imm_extender;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr  = 32'd0;
    logic [2:0]  in_fmt    = 3'd0;

    logic        in_ready,  out_valid,  out_illegal;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;

    always #5 clk = ~clk;

    keen_imm_extender #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    keen_imm_extender #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_illegal(out_illegal64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic        ill;
    } beat_t;

    beat_t       q[$];
    int          total = 0;
    int          bad   = 0;
    logic        armed = 1'b0;
    logic [63:0] pend_imm = 64'd0;
    logic        pend_ill = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_imm = 32'd0;
    logic        last_acc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Immediate rebuilt from bit positions with integer arithmetic, then
    // interpreted as a two's complement number of the field width.
    function automatic logic [63:0] model(input logic [31:0] w, input logic [2:0] f,
                                          output logic ill);
        longint unsigned x;
        longint          v;
        int              width;
        x = 64'(w);
        v = 0;
        width = 0;
        ill = 1'b0;
        case (f)
            3'd0: begin v = longint'((x >> 20) & 64'hFFF); width = 12; end
            3'd1: begin v = longint'(((x >> 25) << 5) | ((x >> 7) & 31)); width = 12; end
            3'd2: begin
                v = longint'(((x >> 31) << 12) | (((x >> 7) & 1) << 11) |
                             (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1));
                width = 13;
            end
            3'd3: begin v = longint'(x & 64'hFFFFF000); width = 32; end
            3'd4: begin
                v = longint'(((x >> 31) << 20) | (((x >> 12) & 255) << 12) |
                             (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1));
                width = 21;
            end
            3'd5: begin v = longint'((x >> 15) & 31); width = 0; end
            default: ill = 1'b1;
        endcase
        if (width > 0 && v >= (longint'(1) << (width - 1)))
            v = v - (longint'(1) << width);
        return 64'(v);
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [2:0] fmt,
                                 input logic ordy, input logic [63:0] eimm, input logic eill);
        in_valid  = v;
        in_instr  = instr;
        in_fmt    = fmt;
        out_ready = ordy;
        pend_imm  = eimm;
        pend_ill  = eill;
    endtask

    task automatic checkOutput();
        logic exp_rdy, acc, cons;
        @(negedge clk);
`ifdef KEEN_IMM_EXTENDER_SKID_EN
        exp_rdy = armed && (q.size() < 2);
`else
        exp_rdy = armed && (q.size() == 0 || out_ready);
`endif
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready64", in_ready64, exp_rdy);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_valid64", out_valid64, q.size() != 0);
        if (q.size() != 0) begin
            chk("imm32", out_imm, q[0].imm[31:0]);
            chk("imm64", out_imm64, q[0].imm);
            chk("illegal", out_illegal, q[0].ill);
            chk("illegal64", out_illegal64, q[0].ill);
        end
        if (prev_stall) chk("stable", out_imm, prev_imm);
        prev_stall = out_valid && !out_ready;
        prev_imm   = out_imm;
        acc  = in_valid && in_ready;
        cons = out_valid && out_ready;
        @(posedge clk);
        if (cons && q.size() != 0) void'(q.pop_front());
        if (acc) q.push_back('{pend_imm, pend_ill});
        last_acc = acc;
        #1;
    endtask

    task automatic sendDirected(input logic [31:0] instr, input logic [2:0] fmt,
                                input logic [63:0] e64, input logic eill);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, instr, fmt, 1'b1, e64, eill);
            checkOutput();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] ri;
        logic [2:0]  rf;
        logic        rill;
        logic [63:0] rimm;
        int          k;

        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_illegal", out_illegal, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        armed = 1'b1;

        $display("[TB] directed formats");
        sendDirected(32'hFFF00093, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        sendDirected(32'h7FF00093, 3'd0, 64'h00000000_000007FF, 1'b0);
        sendDirected(32'hFE112E23, 3'd1, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        sendDirected(32'h80000063, 3'd2, 64'hFFFFFFFF_FFFFF000, 1'b0);
        sendDirected(32'h123450B7, 3'd3, 64'h00000000_12345000, 1'b0);
        sendDirected(32'h800000B7, 3'd3, 64'hFFFFFFFF_80000000, 1'b0);
        sendDirected(32'h8000006F, 3'd4, 64'hFFFFFFFF_FFF00000, 1'b0);
        sendDirected(32'h000F8073, 3'd5, 64'h00000000_0000001F, 1'b0);
        sendDirected(32'hFFFFFFFF, 3'd6, 64'd0, 1'b1);
        sendDirected(32'h7FF00093, 3'd0, 64'h00000000_000007FF, 1'b0);
        sendDirected(32'h12345678, 3'd7, 64'd0, 1'b1);
        repeat (2) begin
            applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
            checkOutput();
        end

        $display("[TB] back-pressure");
        k = 1;
        for (int c = 0; c < 40 && k <= 5; c++) begin
            applyStimulus(1'b1, (k << 20) | 32'h13, 3'd0, c >= 4, 64'(k), 1'b0);
            checkOutput();
            if (last_acc) k++;
        end
        chk("bp_sent", 64'(k), 64'd6);
        repeat (4) begin
            applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
            checkOutput();
        end

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            ri   = $urandom;
            rf   = 3'($urandom_range(7));
            rimm = model(ri, rf, rill);
            applyStimulus($urandom_range(3) != 0, ri, rf, $urandom_range(9) < 7, rimm, rill);
            checkOutput();
        end

        $display("[TB] reset mid-stream");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 32'h00300013 + 32'(c << 20), 3'd0, 1'b0, 64'(3 + c), 1'b0);
            checkOutput();
        end
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_imm", out_imm, 32'd0);
        chk("midrst_valid64", out_valid64, 1'b0);
        q.delete();
        prev_stall = 1'b0;
        armed = 1'b0;
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        armed = 1'b1;
        repeat (2) begin
            applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
            checkOutput();
        end
        sendDirected(32'h00700013, 3'd0, 64'd7, 1'b0);
        applyStimulus(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
        checkOutput();
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
